alu_ext_ctl: RTL
================

Name: alu_ext_ctl

Overview:
- Sequencer and owner of the eJ32 external ALU units: the multi-cycle divider, the 32x32 multiplier and the shifters.
- Accepts one arithmetic request at a time from the core over a valid/ready handshake and starts the divider.
- Handles signed/unsigned operand conversion, divide-by-zero and result sign fix-up.
- Returns a single 32-bit result with a valid/ready response; the core stalls on req_rdy/rsp_vld.

Parameters:
DSZ, 32, datapath width; divider iteration count equals DSZ

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_vld  in  1  request valid
req_rdy  out  1  controller can accept request
req_op  in  3  0 MUL, 1 MULH, 2 DIV, 3 REM, 4 SHL, 5 SHR, 6 USHR, 7 reserved
req_a  in  DSZ  operand a (dividend / multiplicand / shift data)
req_b  in  DSZ  operand b (divisor / multiplier / shift count, low 5 bits)
rsp_vld  out  1  result valid
rsp_rdy  in  1  core accepts result
rsp_d  out  DSZ  result
rsp_err  out  1  divide-by-zero or reserved op
div_rst  out  1  divider start pulse
div_x  out  DSZ  divider dividend (magnitude)
div_y  out  DSZ  divider divisor (magnitude)
div_busy  in  1  divider busy
div_z  in  1  divider zero-divisor flag (unused for control; checked locally)
div_q  in  DSZ  divider quotient
div_r  in  DSZ  divider remainder

Behaviour:
- Reset: state IDLE, req_rdy=1, rsp_vld=0, rsp_d=0, rsp_err=0, div_rst=0, div_x=0, div_y=0.
- States: IDLE, START, WAIT, RESP.
- Request acceptance happens on an edge where req_vld && req_rdy. req_rdy=1 only in IDLE.
- IDLE, op 0/1/4/5/6: compute combinationally, register rsp_d, go to RESP. rsp_vld is high the cycle after acceptance (latency 1).
  - MUL: low DSZ bits of signed a*b.
  - MULH: high DSZ bits of signed 2*DSZ product.
  - SHL: a << b[4:0].
  - SHR: arithmetic right shift.
  - USHR: logical right shift.
- IDLE, op 7: rsp_d=0, rsp_err=1, go to RESP (latency 1).
- IDLE, op 2/3 with b==0: rsp_d=0, rsp_err=1, go to RESP. The divider is not started.
- IDLE, op 2/3 with b!=0: latch op, sign_a=a[DSZ-1], sign_q=a[DSZ-1]^b[DSZ-1]; div_x=|a|, div_y=|b| (two's complement magnitude, unsigned). Go to START.
- START: div_rst=1 for exactly one cycle, go to WAIT. div_x/div_y stay stable until RESP.
- WAIT: div_busy is ignored in the first WAIT cycle, because the divider's registered busy only becomes valid then. On the first cycle with div_busy==0 after that:
  - DIV: rsp_d = sign_q ? -div_q : div_q.
  - REM: rsp_d = sign_a ? -div_r : div_r.
  - Go to RESP.
  - DIV/REM rsp_vld is first high 35 cycles after acceptance (DSZ=32).
- Division rounds toward zero; the remainder takes the dividend's sign. MIN/-1 gives MIN with rsp_err=0.
- RESP: rsp_vld=1, and rsp_d/rsp_err are held stable until rsp_rdy. On the rsp_rdy edge: rsp_vld=0, rsp_err=0, go to IDLE.
  - The next request can be accepted the cycle after that edge; there is no back-to-back acceptance in the RESP cycle.
- rst in any state, including mid-division: return to IDLE with reset values next cycle.
  - A divider already running is abandoned; its later busy fall is ignored because the controller only samples busy in WAIT.
- req_a/req_b/req_op changing while not accepted have no effect.

Optional Feature:
DIV_CACHE_EN
- Defined:
  - Keep a cache of the last completed division: signed a, b, corrected quotient, corrected remainder, and a valid bit.
  - The valid bit is cleared on rst and set on WAIT exit.
  - A DIV/REM with b!=0 whose a,b match the cache returns the cached result with latency 1, with no div_rst. This makes a Forth /MOD pair cost one division.
  - Cache capture happens in WAIT for both quotient and remainder, regardless of op.
- Undefined: every nonzero-divisor DIV/REM runs the divider; no cache registers.

Test Plan:
- MUL a=-3 (0xFFFFFFFD), b=7 -> rsp_d=0xFFFFFFEB, err=0, rsp_vld 1 cycle after accept. MULH same operands -> 0xFFFFFFFF.
- DIV a=-7, b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. Each takes 35 cycles to rsp_vld; div_rst is a single-cycle pulse; div_x=7, div_y=2.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000, err=0. DIV a=5, b=0 -> rsp_d=0, err=1, latency 1, div_rst never asserted.
- SHR a=0x80000010, b=0x24 (uses 4) -> 0xF8000001. USHR same -> 0x08000001. SHL a=1, b=31 -> 0x80000000.
- Hold rsp_rdy=0 for 10 cycles after rsp_vld: rsp_d stable, req_rdy=0, new req_vld is ignored. Assert rst at cycle 10 of a division: next cycle IDLE, req_rdy=1; a following MUL 6*7 -> 42 with correct latency.
- DIV_CACHE_EN: DIV 100/7 (35 cycles) -> 14, then REM 100/7 -> 2 in 1 cycle with no div_rst. After rst, the same REM takes 35 cycles.

Source files
------------

// File: rtl/alu_ext_if.sv
//------------------------------------------------------------------------------
// alu_ext_if : core <-> external ALU request/response handshake bundle.
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface alu_ext_if #(
    parameter int DSZ = 32
);
    logic           req_vld;
    logic           req_rdy;
    logic [2:0]     req_op;
    logic [DSZ-1:0] req_a;
    logic [DSZ-1:0] req_b;
    logic           rsp_vld;
    logic           rsp_rdy;
    logic [DSZ-1:0] rsp_d;
    logic           rsp_err;

    modport master (
        output req_vld, req_op, req_a, req_b, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_d, rsp_err
    );

    modport slave (
        input  req_vld, req_op, req_a, req_b, rsp_rdy,
        output req_rdy, rsp_vld, rsp_d, rsp_err
    );
endinterface

`default_nettype wire

// File: rtl/alu_ext_ctl.sv
//------------------------------------------------------------------------------
// alu_ext_ctl : sequencer for the eJ32 external multiplier, shifters, divider.
// Optional macro DIV_CACHE_EN keeps the last division result for /MOD pairs.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_ext_ctl #(
    parameter int DSZ = 32
) (
    input  wire logic           clk,
    input  wire logic           rst,
    alu_ext_if.slave            bus,
    output logic                div_rst,
    output logic [DSZ-1:0]      div_x,
    output logic [DSZ-1:0]      div_y,
    input  wire logic           div_busy,
    input  wire logic           div_z,
    input  wire logic [DSZ-1:0] div_q,
    input  wire logic [DSZ-1:0] div_r
);
    localparam int SHW = $clog2(DSZ);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [2:0] OP_MUL  = 3'd0;
    localparam logic [2:0] OP_MULH = 3'd1;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_REM  = 3'd3;
    localparam logic [2:0] OP_SHL  = 3'd4;
    localparam logic [2:0] OP_SHR  = 3'd5;
    localparam logic [2:0] OP_USHR = 3'd6;

    state_t         state_q, state_d;
    logic           req_rdy_q, req_rdy_d;
    logic           rsp_vld_q, rsp_vld_d;
    logic [DSZ-1:0] rsp_d_q, rsp_d_d;
    logic           rsp_err_q, rsp_err_d;
    logic           div_rst_q, div_rst_d;
    logic [DSZ-1:0] div_x_q, div_x_d;
    logic [DSZ-1:0] div_y_q, div_y_d;
    logic           is_div_q, is_div_d;
    logic           sign_a_q, sign_a_d;
    logic           sign_q_q, sign_q_d;
    logic           first_q, first_d;

    // div_z is redundant with the local zero-divisor check.
    logic unused_div_z;
    assign unused_div_z = div_z;

    logic [2*DSZ-1:0] prod_w;
    logic [SHW-1:0]   shamt_w;
    logic [DSZ-1:0]   quo_fix_w;
    logic [DSZ-1:0]   rem_fix_w;
    logic             cache_hit_w;

    // Low 2*DSZ bits of the sign-extended product equal the signed product.
    assign prod_w    = {{DSZ{bus.req_a[DSZ-1]}}, bus.req_a} * {{DSZ{bus.req_b[DSZ-1]}}, bus.req_b};
    assign shamt_w   = bus.req_b[SHW-1:0];
    assign quo_fix_w = sign_q_q ? -div_q : div_q;
    assign rem_fix_w = sign_a_q ? -div_r : div_r;

`ifdef DIV_CACHE_EN
    logic           ca_vld_q, ca_vld_d;
    logic [DSZ-1:0] ca_a_q, ca_a_d;
    logic [DSZ-1:0] ca_b_q, ca_b_d;
    logic [DSZ-1:0] ca_quo_q, ca_quo_d;
    logic [DSZ-1:0] ca_rem_q, ca_rem_d;
    assign cache_hit_w = ca_vld_q && (bus.req_a == ca_a_q) && (bus.req_b == ca_b_q);
`else
    assign cache_hit_w = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        req_rdy_d = req_rdy_q;
        rsp_vld_d = rsp_vld_q;
        rsp_d_d   = rsp_d_q;
        rsp_err_d = rsp_err_q;
        div_rst_d = 1'b0;
        div_x_d   = div_x_q;
        div_y_d   = div_y_q;
        is_div_d  = is_div_q;
        sign_a_d  = sign_a_q;
        sign_q_d  = sign_q_q;
        first_d   = 1'b0;
`ifdef DIV_CACHE_EN
        ca_vld_d  = ca_vld_q;
        ca_a_d    = ca_a_q;
        ca_b_d    = ca_b_q;
        ca_quo_d  = ca_quo_q;
        ca_rem_d  = ca_rem_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req_vld) begin
                    state_d   = ST_RESP;
                    req_rdy_d = 1'b0;
                    rsp_vld_d = 1'b1;
                    rsp_err_d = 1'b0;
                    rsp_d_d   = '0;
                    case (bus.req_op)
                        OP_MUL:  rsp_d_d = prod_w[DSZ-1:0];
                        OP_MULH: rsp_d_d = prod_w[2*DSZ-1:DSZ];
                        OP_SHL:  rsp_d_d = bus.req_a << shamt_w;
                        OP_SHR:  rsp_d_d = $signed(bus.req_a) >>> shamt_w;
                        OP_USHR: rsp_d_d = bus.req_a >> shamt_w;
                        OP_DIV, OP_REM: begin
                            if (bus.req_b == '0) begin
                                rsp_err_d = 1'b1;
                            end else if (cache_hit_w) begin
`ifdef DIV_CACHE_EN
                                rsp_d_d = (bus.req_op == OP_DIV) ? ca_quo_q : ca_rem_q;
`endif
                            end else begin
                                state_d   = ST_START;
                                rsp_vld_d = 1'b0;
                                div_rst_d = 1'b1;
                                is_div_d  = (bus.req_op == OP_DIV);
                                sign_a_d  = bus.req_a[DSZ-1];
                                sign_q_d  = bus.req_a[DSZ-1] ^ bus.req_b[DSZ-1];
                                div_x_d   = bus.req_a[DSZ-1] ? -bus.req_a : bus.req_a;
                                div_y_d   = bus.req_b[DSZ-1] ? -bus.req_b : bus.req_b;
`ifdef DIV_CACHE_EN
                                ca_vld_d  = 1'b0;
                                ca_a_d    = bus.req_a;
                                ca_b_d    = bus.req_b;
`endif
                            end
                        end
                        default: rsp_err_d = 1'b1;
                    endcase
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
                first_d = 1'b1;
            end
            ST_WAIT: begin
                // Divider busy is not yet meaningful in the first WAIT cycle.
                if (!first_q && !div_busy) begin
                    state_d   = ST_RESP;
                    rsp_vld_d = 1'b1;
                    rsp_d_d   = is_div_q ? quo_fix_w : rem_fix_w;
`ifdef DIV_CACHE_EN
                    ca_vld_d  = 1'b1;
                    ca_quo_d  = quo_fix_w;
                    ca_rem_d  = rem_fix_w;
`endif
                end
            end
            default: begin
                if (bus.rsp_rdy) begin
                    state_d   = ST_IDLE;
                    rsp_vld_d = 1'b0;
                    rsp_err_d = 1'b0;
                    req_rdy_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            req_rdy_q <= 1'b1;
            rsp_vld_q <= 1'b0;
            rsp_d_q   <= '0;
            rsp_err_q <= 1'b0;
            div_rst_q <= 1'b0;
            div_x_q   <= '0;
            div_y_q   <= '0;
            is_div_q  <= 1'b0;
            sign_a_q  <= 1'b0;
            sign_q_q  <= 1'b0;
            first_q   <= 1'b0;
`ifdef DIV_CACHE_EN
            ca_vld_q  <= 1'b0;
            ca_a_q    <= '0;
            ca_b_q    <= '0;
            ca_quo_q  <= '0;
            ca_rem_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            req_rdy_q <= req_rdy_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_d_q   <= rsp_d_d;
            rsp_err_q <= rsp_err_d;
            div_rst_q <= div_rst_d;
            div_x_q   <= div_x_d;
            div_y_q   <= div_y_d;
            is_div_q  <= is_div_d;
            sign_a_q  <= sign_a_d;
            sign_q_q  <= sign_q_d;
            first_q   <= first_d;
`ifdef DIV_CACHE_EN
            ca_vld_q  <= ca_vld_d;
            ca_a_q    <= ca_a_d;
            ca_b_q    <= ca_b_d;
            ca_quo_q  <= ca_quo_d;
            ca_rem_q  <= ca_rem_d;
`endif
        end
    end

    assign bus.req_rdy = req_rdy_q;
    assign bus.rsp_vld = rsp_vld_q;
    assign bus.rsp_d   = rsp_d_q;
    assign bus.rsp_err = rsp_err_q;
    assign div_rst     = div_rst_q;
    assign div_x       = div_x_q;
    assign div_y       = div_y_q;

endmodule

`default_nettype wire
